apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Two-requester APB master: shares one APB bus between the processor-side port (req0) and a second master (req1, e.g. the I2C engine's DMA path).
- Arbitrates round-robin and sequences each transfer through the APB SETUP/ACCESS phases.
- Handles wait states, slave errors and a hung-slave timeout.
- Sits between the processor bus and the APB peripheral fabric (I2C controller registers and others).

Parameters:
ADDR_W, 8, APB address width
DATA_W, 8, APB data width
TIMEOUT, 16, max ACCESS cycles without pready before forced error completion (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 transfer request; held until req0_done
req0_write  input  1  1 = write, 0 = read
req0_addr  input  ADDR_W  transfer address
req0_wdata  input  DATA_W  write data
req0_done  output  1  one-cycle completion pulse
req0_rdata  output  DATA_W  read data, valid with req0_done
req0_err  output  1  error flag, valid with req0_done
req1_valid, req1_write, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: same as req0, for requester 1
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset: async on rst=1. All outputs 0, state=IDLE, owner=0, last_grant=1 (req0 wins first tie), wait counter=0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requester: reqN_valid=1 and reqN_done=0 in this cycle. This stops re-granting a requester on the cycle its done pulses.
  - One eligible requester: grant it.
  - Both eligible: grant the one != last_grant.
  - On grant: latch write/addr/wdata into paddr/pwrite/pwdata, set owner and last_grant, go to SETUP.
- SETUP: psel=1, penable=0, exactly one cycle, then go to ACCESS. Clear wait counter.
- ACCESS: psel=1, penable=1. Sample pready each cycle.
  - pready=1: next cycle is IDLE with owner's done=1, err=pslverr, rdata=prdata for reads (0 for writes). psel/penable=0.
  - pready=0: increment counter. If counter reaches TIMEOUT-1 with pready still 0: complete with err=1, rdata=0.
- Non-owner done/rdata/err stay 0. rdata/err hold their value only during the done cycle, then return to 0.
- paddr/pwrite/pwdata are stable from SETUP through the last ACCESS cycle, and hold their last value in IDLE.
- Minimum transfer is 3 cycles (SETUP, ACCESS, done/IDLE). Back-to-back grant happens from that IDLE cycle.
- reqN_valid dropping mid-transfer: ignored. The transfer completes and done still pulses.
- Input changes on the owner's request lines after the grant have no effect on the current transfer.
- Reset mid-transfer: psel/penable drop immediately (async). No done pulse. Arbitration restarts from req0 priority.

Test Plan:
- Single write, zero wait: req0 write addr=0x12, wdata=0xA5, pready=1 throughout -> psel 1 for 2 cycles, penable high in cycle 2, paddr=0x12, pwdata=0xA5, pwrite=1. req0_done pulses 1 cycle with err=0.
- Read, 2 wait states: req1 read addr=0x04, pready low 2 ACCESS cycles then high with prdata=0x3C -> penable high 3 cycles. req1_done with req1_rdata=0x3C, err=0.
- Simultaneous requests held continuously (both valid=1, each re-asserted after its done) -> grants alternate 0,1,0,1 starting with 0. No cycle where both done=1.
- Slave error: req0 write, pready=1 with pslverr=1 -> req0_done=1, req0_err=1.
- Timeout: req1 read, pready stuck 0, TIMEOUT=16 -> ACCESS lasts 16 cycles, then req1_done=1, err=1, rdata=0. Bus returns to IDLE and serves a pending req0 next.
- Reset in ACCESS: assert rst during a wait state -> psel=penable=0 the same cycle, no done pulse. After release, with both requests valid, req0 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - APB bus bundle between the arbiter (master) and the peripheral fabric (slave)
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin APB master with wait states, slave error and timeout
module apb_req_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_done_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  output logic              req0_err_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_done_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              req1_err_o,
  apb_req_arbiter_if.master apb
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              elig0, elig1, grant1, finish;
  logic              fin_err;
  logic [DATA_W-1:0] fin_rdata;

  // Bus strobes decode straight from state so an async reset drops them at once
  assign apb.psel    = (state_q != IDLE);
  assign apb.penable = (state_q == ACCESS);
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

  assign req0_done_o  = done0_q;
  assign req0_err_o   = err0_q;
  assign req0_rdata_o = rdata0_q;
  assign req1_done_o  = done1_q;
  assign req1_err_o   = err1_q;
  assign req1_rdata_o = rdata1_q;

  // A requester whose done is pulsing this cycle is not eligible, so it is not re-granted
  assign elig0  = req0_valid_i & ~done0_q;
  assign elig1  = req1_valid_i & ~done1_q;
  assign grant1 = elig1 & (~elig0 | ~last_q);

  // State register and latched transfer fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Arbitration, APB phase sequencing and completion reporting
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = '0;
    rdata1_d  = '0;
    finish    = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          owner_d  = grant1;
          last_d   = grant1;
          paddr_d  = grant1 ? req1_addr_i  : req0_addr_i;
          pwrite_d = grant1 ? req1_write_i : req0_write_i;
          pwdata_d = grant1 ? req1_wdata_i : req0_wdata_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb.pready) begin
          finish    = 1'b1;
          fin_err   = apb.pslverr;
          fin_rdata = pwrite_q ? '0 : apb.prdata;
        end else if (cnt_q == CNT_LAST) begin
          // Hung slave: force an error completion with no read data
          finish  = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      if (owner_q) begin
        done1_d  = 1'b1;
        err1_d   = fin_err;
        rdata1_d = fin_rdata;
      end else begin
        done0_d  = 1'b1;
        err0_d   = fin_err;
        rdata0_d = fin_rdata;
      end
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed vector bench for apb_req_arbiter
module tb_apb_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
  logic [7:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic       req0_done, req0_err, req1_done, req1_err;
  logic [7:0] req0_rdata, req1_rdata;

  apb_req_arbiter_if #(.ADDR_W(8), .DATA_W(8)) apb ();

  apb_req_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_write_i(req0_write), .req0_addr_i(req0_addr),
    .req0_wdata_i(req0_wdata), .req0_done_o(req0_done), .req0_rdata_o(req0_rdata),
    .req0_err_o(req0_err),
    .req1_valid_i(req1_valid), .req1_write_i(req1_write), .req1_addr_i(req1_addr),
    .req1_wdata_i(req1_wdata), .req1_done_o(req1_done), .req1_rdata_o(req1_rdata),
    .req1_err_o(req1_err),
    .apb(apb.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prd;
    logic       serr;
    logic       drop;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_acc;
  } vec_t;

  vec_t vecs[8];
  int n_pass = 0, n_total = 0;
  int slave_waits = 0, acc_cnt = 0;
  logic [7:0] slave_rdata = 0;
  logic slave_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One cycle: move to the falling edge, then answer as the slave for the current cycle
  task automatic step();
    @(negedge clk);
    if (apb.psel && apb.penable) acc_cnt++;
    else acc_cnt = 0;
    apb.pready  = apb.psel && apb.penable && (acc_cnt > slave_waits);
    apb.prdata  = slave_rdata;
    apb.pslverr = slave_err;
  endtask

  task automatic set_req(input logic sel, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    if (sel) begin req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d; end
    else     begin req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d; end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int psel_n = 0, pen_n = 0, bus_bad = 0;
    logic got = 0;
    slave_waits = v.waits; slave_rdata = v.prd; slave_err = v.serr;
    set_req(v.sel, 1'b1, v.wr, v.addr, v.wdata);
    for (int c = 0; c < 64 && !got; c++) begin
      step();
      if (req0_done || req1_done) begin
        got = 1;
        check($sformatf("v%0d_done_who", idx), {req1_done, req0_done}, v.sel ? 2 : 1);
        check($sformatf("v%0d_rdata", idx), v.sel ? req1_rdata : req0_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), v.sel ? req1_err : req0_err, v.exp_err);
        check($sformatf("v%0d_other_quiet", idx),
              v.sel ? {req0_rdata, req0_err} : {req1_rdata, req1_err}, 0);
        check($sformatf("v%0d_idle_on_done", idx), {apb.psel, apb.penable}, 0);
        set_req(v.sel, 1'b0, v.wr, v.addr, v.wdata);
      end else if (apb.psel) begin
        psel_n++;
        if (apb.penable) pen_n++;
        if (apb.paddr !== v.addr || apb.pwrite !== v.wr || apb.pwdata !== v.wdata) bus_bad++;
        set_req(v.sel, !v.drop, v.wr, ~v.addr, ~v.wdata);
      end
    end
    check($sformatf("v%0d_done_seen", idx), got, 1);
    check($sformatf("v%0d_psel_cycles", idx), psel_n, v.exp_acc + 1);
    check($sformatf("v%0d_penable_cycles", idx), pen_n, v.exp_acc);
    check($sformatf("v%0d_bus_stable", idx), bus_bad, 0);
    set_req(v.sel, 1'b0, v.wr, v.addr, v.wdata);
    step();
    check($sformatf("v%0d_pulse_end", idx),
          {req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}, 0);
  endtask

  initial begin
    int pen_n, n_done, both_bad;
    logic got;
    logic order[4];

    apb.pready = 0; apb.prdata = 0; apb.pslverr = 0;
    //           sel wr  addr   wdata  waits prd    serr drop exp_rd exp_err acc
    vecs[0] = '{1'b0, 1'b1, 8'h12, 8'hA5, 0,   8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b0, 8'h04, 8'h00, 2,   8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b1, 8'h20, 8'h5A, 0,   8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 1};
    vecs[3] = '{1'b0, 1'b0, 8'h81, 8'h11, 1,   8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 2};
    vecs[4] = '{1'b1, 1'b1, 8'hFE, 8'h01, 0,   8'h66, 1'b0, 1'b1, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b1, 1'b0, 8'h33, 8'h00, 255, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 16};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 15,  8'h99, 1'b0, 1'b0, 8'h99, 1'b0, 16};
    vecs[7] = '{1'b1, 1'b0, 8'h7F, 8'h22, 14,  8'h42, 1'b0, 1'b0, 8'h42, 1'b0, 15};

    step(); step();
    check("reset_strobes", {apb.psel, apb.penable, apb.pwrite}, 0);
    check("reset_bus", {apb.paddr, apb.pwdata}, 0);
    check("reset_resp", {req0_done, req1_done, req0_err, req1_err, req0_rdata, req1_rdata}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Hung slave on req1 with req0 arriving mid-transfer: req0 is served right after
    slave_waits = 255; slave_rdata = 8'hEE; slave_err = 0;
    set_req(1'b1, 1'b1, 1'b0, 8'h44, 8'h00);
    pen_n = 0; got = 0;
    for (int c = 0; c < 64 && !got; c++) begin
      step();
      if (req1_done || req0_done) begin
        got = 1;
        check("to_done1", {req1_done, req1_err, req1_rdata, req0_done}, {1'b1, 1'b1, 8'h00, 1'b0});
        set_req(1'b1, 1'b0, 1'b0, 8'h44, 8'h00);
      end else if (apb.psel) begin
        if (apb.penable) pen_n++;
        set_req(1'b0, 1'b1, 1'b1, 8'h55, 8'hC7);
      end
    end
    check("to_seen", got, 1);
    check("to_access_cycles", pen_n, 16);
    slave_waits = 0;
    step();
    check("to_next_setup", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata},
          {3'b101, 8'h55, 8'hC7});
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      if (req0_done) got = 1;
    end
    check("to_req0_served", got, 1);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();

    // Reset during an ACCESS wait state of a req0 transfer
    slave_waits = 255;
    set_req(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int c = 0; c < 16 && acc_cnt < 2; c++) step();
    check("rst_in_access_reached", acc_cnt, 2);
    #2 rst = 1'b1;
    #1 check("rst_async_strobes", {apb.psel, apb.penable, req0_done}, 0);
    set_req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
    step();
    check("rst_no_done", {req0_done, req1_done}, 0);
    rst = 1'b0;
    slave_waits = 0;

    // Both requesters held valid: grants alternate starting with req0
    n_done = 0; both_bad = 0;
    for (int c = 0; c < 40 && n_done < 4; c++) begin
      step();
      if (req0_done && req1_done) both_bad++;
      else if (req0_done || req1_done) begin
        order[n_done] = req1_done;
        n_done++;
      end
    end
    check("alt_count", n_done, 4);
    check("alt_both_done", both_bad, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("alt_order%0d", i), (i < n_done) ? order[i] : 1'bx, i[0]);
    set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
